// File: rtl/rx_serial_7e2.sv
// rx_serial_7e2: 7E2 UART receiver with mid-bit sampling; RX_OVERRUN_EN adds erro_overrun
module rx_serial_7e2 #(
  parameter int DATA_BITS     = 7,
  parameter int TICKS_PER_BIT = 434,
  parameter int HALF_TICKS    = TICKS_PER_BIT / 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 entrada_serial,
  input  logic                 limpa,
  output logic [DATA_BITS-1:0] dado_recebido,
  output logic                 pronto,
  output logic                 tem_dado,
  output logic                 erro_paridade,
  output logic                 erro_stop,
`ifdef RX_OVERRUN_EN
  output logic                 erro_overrun,
`endif
  output logic [3:0]           db_estado
);
  localparam int TW = $clog2(TICKS_PER_BIT) + 1;
  localparam int NW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] HALF_M1 = TW'(HALF_TICKS - 1);
  localparam logic [TW-1:0] BIT_M1  = TW'(TICKS_PER_BIT - 1);
  localparam logic [NW-1:0] LAST    = NW'(DATA_BITS - 1);
  typedef enum logic [2:0] {OCIOSO, INICIO, DADOS, PARIDADE, STOP1, STOP2, FIM, ESPERA} state_t;
  state_t state, next;
  logic s1, rx_s;
  logic [TW-1:0] tick;
  logic [NW-1:0] nbits;
  logic [DATA_BITS-1:0] sr;
  logic perr, ferr, done, last, fim, busy;
  // two-flop synchronizer; idles high so reset never looks like a start bit
  always_ff @(posedge clock or posedge reset)
    if (reset) {s1, rx_s} <= 2'b11;
    else {s1, rx_s} <= {entrada_serial, s1};
  // state register
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= OCIOSO;
    else state <= next;
  // next-state logic
  always_comb begin
    next = state;
    case (state)
      OCIOSO:   next = rx_s ? OCIOSO : INICIO;
      INICIO:   next = done ? (rx_s ? OCIOSO : DADOS) : INICIO;
      DADOS:    next = done && last ? PARIDADE : DADOS;
      PARIDADE: next = done ? STOP1 : PARIDADE;
      STOP1:    next = done ? STOP2 : STOP1;
      STOP2:    next = done ? FIM : STOP2;
      FIM:      next = ferr ? ESPERA : OCIOSO;
      ESPERA:   next = rx_s ? OCIOSO : ESPERA;
      default:  next = OCIOSO;
    endcase
  end
  // state decode: bit-period end, last data bit, frame completion
  always_comb begin
    busy = state inside {INICIO, DADOS, PARIDADE, STOP1, STOP2};
    done = tick == (state == INICIO ? HALF_M1 : BIT_M1);
    last = nbits == LAST;
    fim = state == FIM;
    db_estado = {1'b0, state};
  end
  // bit timing, shift register and per-frame error capture
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      tick <= '0;
      nbits <= '0;
      sr <= '0;
      perr <= 1'b0;
      ferr <= 1'b0;
    end else begin
      tick <= busy && !done ? tick + 1'b1 : '0;
      nbits <= state == OCIOSO ? '0 : state == DADOS && done ? nbits + 1'b1 : nbits;
      sr <= state == DADOS && done ? {rx_s, sr[DATA_BITS-1:1]} : sr;
      perr <= state == PARIDADE && done ? (^sr) ^ rx_s : perr;
      ferr <= state == OCIOSO ? 1'b0 : (state == STOP1 || state == STOP2) && done && !rx_s ? 1'b1 : ferr;
    end
  // consumer-facing outputs; a completing frame wins over a same-cycle limpa
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      dado_recebido <= '0;
      pronto <= 1'b0;
      tem_dado <= 1'b0;
      erro_paridade <= 1'b0;
      erro_stop <= 1'b0;
`ifdef RX_OVERRUN_EN
      erro_overrun <= 1'b0;
`endif
    end else begin
      dado_recebido <= fim ? sr : dado_recebido;
      pronto <= fim;
      tem_dado <= fim | (tem_dado & ~limpa);
      erro_paridade <= (fim & perr) | (erro_paridade & ~limpa);
      erro_stop <= (fim & ferr) | (erro_stop & ~limpa);
`ifdef RX_OVERRUN_EN
      erro_overrun <= (fim & tem_dado & ~limpa) | (erro_overrun & ~limpa);
`endif
    end
endmodule

// File: doc/rx_serial_7e2.md
Name: rx_serial_7e2

Overview:
UART receiver for 7E2 frames: 1 start bit, 7 data bits LSB first, even parity, 2 stop bits.
- Counterpart of the team's serial transmitter; drives the receive path and the hex displays in the serial top.
- Samples `entrada_serial` at mid-bit using a tick counter and presents each received character with ready/error flags.
- Holds the character until the consumer clears it.

Parameters:
- DATA_BITS, 7, data bits per frame.
- TICKS_PER_BIT, 434, clock cycles per bit (50 MHz / 115200 baud); benches use 16.
- HALF_TICKS, TICKS_PER_BIT/2, start-bit mid-point offset.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- entrada_serial  input  1  serial line, idle high; asynchronous to clock.
- limpa  input  1  consumer acknowledge; clears `tem_dado` and error flags.
- dado_recebido  output  DATA_BITS  last received character.
- pronto  output  1  one-cycle pulse when a frame completes.
- tem_dado  output  1  sticky "character available".
- erro_paridade  output  1  parity error on last frame, sticky until `limpa`.
- erro_stop  output  1  framing error (either stop bit low), sticky until `limpa`.
- db_estado  output  4  current FSM state code, for debug.

Behaviour:
- Reset: all outputs 0, FSM in OCIOSO, counters 0, synchronizer flops 1. Reset mid-frame aborts the frame with no `pronto`.
- Synchronizer: `entrada_serial` passes through 2 flops; all logic uses the synchronized value `rx_s`.
- FSM states and codes:
  - OCIOSO 0: wait for `rx_s`=0, then go to INICIO with tick counter cleared.
  - INICIO 1: count HALF_TICKS. Then `rx_s`=0 goes to DADOS; `rx_s`=1 is a glitch and returns to OCIOSO with no flags.
  - DADOS 2: every TICKS_PER_BIT sample `rx_s` into the shift register, LSB first. After DATA_BITS samples, go to PARIDADE.
  - PARIDADE 3: after TICKS_PER_BIT sample the parity bit. Error if XOR(data, parity) is not 0.
  - STOP1 4 / STOP2 5: each samples after TICKS_PER_BIT.
    - Either sample 0: set the internal framing flag.
    - STOP1 low still proceeds to STOP2.
    - After STOP2 go to FIM.
  - FIM 6 (one cycle): load `dado_recebido`, set `pronto`=1. Set `erro_paridade` and `erro_stop` if flagged (OR into sticky), set `tem_dado`. Then:
    - if a stop error occurred, go to ESPERA;
    - otherwise go to OCIOSO.
  - ESPERA 7: wait for `rx_s`=1, then go to OCIOSO. This prevents a stuck-low line from being read as a new start.
- Data is loaded even on error; the error flags qualify it.
- Latency: `pronto` rises 10*TICKS_PER_BIT + HALF_TICKS + 3 cycles (±1) after the falling edge of the start bit on `entrada_serial`.
- Back-to-back frames: OCIOSO is re-entered during the second stop bit's last half. A start edge immediately after stop2 must be received.
- `limpa` and FIM in the same cycle: set wins; the new data is flagged and errors reflect the new frame only.
- `limpa` while OCIOSO with `tem_dado`=0: no effect.
- Tick counter width is clog2(TICKS_PER_BIT)+1; it never wraps inside a bit.

Optional Feature:
RX_OVERRUN_EN
- Defined: adds output `erro_overrun` (1 bit, reset 0). Set in FIM when `tem_dado`=1 and `limpa`=0; cleared by `limpa`. `dado_recebido` is still overwritten with the new character.
- Undefined: port absent; new data overwrites silently.

Test Plan:
- TICKS_PER_BIT=16, send 'C' (0x43, parity 1, stops 1,1) -> `pronto` pulse once, `dado_recebido`=0x43, `tem_dado`=1, both error flags 0. `limpa` then clears `tem_dado`.
- Send 0x43 with parity 0 -> `dado_recebido`=0x43, `erro_paridade`=1, `erro_stop`=0.
- Send 0x35 with STOP1=0 and the line held low for 40 cycles -> `erro_stop`=1. FSM stays in ESPERA (`db_estado`=7) until the line rises, then OCIOSO.
- 4-cycle low glitch on an idle line -> no `pronto`, FSM returns to OCIOSO, all outputs unchanged.
- Two back-to-back frames 0x41 then 0x7F with no idle gap -> two `pronto` pulses, final `dado_recebido`=0x7F. With RX_OVERRUN_EN and no `limpa` -> `erro_overrun`=1.
- Assert `reset` mid-DADOS of frame 0x55 -> all outputs 0 immediately. A following full frame 0x2A is received correctly.
